// File: rtl/shift_pkg.sv
// Shared constants and types for the dual-lane serial capture block.
package shift_pkg;
  localparam int WIDTH_DEF = 8;

  // Counter counts down from WIDTH-2 to 0, so it only needs to hold WIDTH-2.
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w - 1) : 1;
  endfunction

  localparam int CNT_W = cnt_width(WIDTH_DEF);

  typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/sipo_lane.sv
// Single-lane MSB-first serial-in shift register; word presents the value after the next shift.
module sipo_lane
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             d,
  output logic [WIDTH-1:0] word
);
  logic [WIDTH-1:0] sh_q;

  assign word = {sh_q[WIDTH-2:0], d};

  always_ff @(posedge clk) begin
    if (rst)     sh_q <= '0;
    else if (en) sh_q <= word;
  end
endmodule

// File: rtl/serial_capture_8bit.sv
// Two-lane serial word capture with a single-entry hold register, overrun and framing flags.
module serial_capture_8bit
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic             A,
  input  logic             B,
  input  logic             Ack,
  output logic [WIDTH-1:0] Data_A,
  output logic [WIDTH-1:0] Data_B,
  output logic             Valid,
  output logic             Busy,
  output logic             Overrun,
  output logic             Frame_Err
);
  localparam int NUM_LANES = 2;
  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LOAD = CW'(WIDTH - 2);

  state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic    done, fe_set, shift_en;
  logic [NUM_LANES-1:0]            lane_d;
  logic [NUM_LANES-1:0][WIDTH-1:0] lane_word;

  // A restart never clears the lanes: stale bits shift out before the next completion.
  assign shift_en = Start | (state_q == SHIFT);
  assign lane_d   = {B, A};
  assign Busy     = (state_q == SHIFT);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    sipo_lane #(.WIDTH(WIDTH)) u_lane (
      .clk (CLK),
      .rst (Reset),
      .en  (shift_en),
      .d   (lane_d[g]),
      .word(lane_word[g])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    fe_set  = 1'b0;
    case (state_q)
      IDLE: if (Start) begin
        state_d = SHIFT;
        cnt_d   = LOAD;
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          // Bit-0 cycle: a Start here chains straight into the next word.
          done    = 1'b1;
          state_d = Start ? SHIFT : IDLE;
          cnt_d   = Start ? LOAD : '0;
        end else if (Start) begin
          fe_set = 1'b1;
          cnt_d  = LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      Data_A    <= '0;
      Data_B    <= '0;
      Valid     <= 1'b0;
      Overrun   <= 1'b0;
      Frame_Err <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (done) begin
        if (!Valid || Ack) begin
          Data_A <= lane_word[0];
          Data_B <= lane_word[1];
          Valid  <= 1'b1;
        end else begin
          Overrun <= 1'b1;
        end
      end else if (Valid && Ack) begin
        Valid <= 1'b0;
      end
      if (fe_set) Frame_Err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_serial_capture_8bit.sv
// Directed and random stimulus against a bit-collecting reference model of the capture block.
module tb_serial_capture_8bit;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         Reset = 1'b1, Start = 1'b0, A = 1'b0, B = 1'b0, Ack = 1'b0;
  logic [W-1:0] Data_A, Data_B;
  logic         Valid, Busy, Overrun, Frame_Err;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit     m_busy, m_valid, m_ovr, m_fe;
  int     m_cnt, m_wa, m_wb;
  int     m_da, m_db;

  serial_capture_8bit #(.WIDTH(W)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .A(A), .B(B), .Ack(Ack),
    .Data_A(Data_A), .Data_B(Data_B), .Valid(Valid), .Busy(Busy),
    .Overrun(Overrun), .Frame_Err(Frame_Err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: a word is the WIDTH bits collected since the last Start; it completes on the WIDTH-th bit.
  task automatic model(input bit rst, st, a, b, ack);
    bit comp;
    if (rst) begin
      m_busy = 0; m_valid = 0; m_ovr = 0; m_fe = 0;
      m_cnt = 0; m_wa = 0; m_wb = 0; m_da = 0; m_db = 0;
      return;
    end
    comp = m_busy && (m_cnt == W - 1);
    if (comp) begin
      if (!m_valid || ack) begin
        m_da = (m_wa * 2 + a) % (1 << W);
        m_db = (m_wb * 2 + b) % (1 << W);
        m_valid = 1;
      end else m_ovr = 1;
    end else if (m_valid && ack) m_valid = 0;
    if (st) begin
      if (m_busy && !comp) m_fe = 1;
      m_wa = a; m_wb = b; m_cnt = 1; m_busy = 1;
    end else if (m_busy) begin
      if (comp) m_busy = 0;
      else begin
        m_wa = m_wa * 2 + a; m_wb = m_wb * 2 + b; m_cnt++;
      end
    end
  endtask

  task automatic cyc(input bit rst, st, a, b, ack);
    Reset = rst; Start = st; A = a; B = b; Ack = ack;
    @(posedge CLK);
    model(rst, st, a, b, ack);
    #1;
    chk("busy", 32'(Busy), 32'(m_busy));
    chk("valid", 32'(Valid), 32'(m_valid));
    chk("data_a", 32'(Data_A), 32'(m_da));
    chk("data_b", 32'(Data_B), 32'(m_db));
    chk("overrun", 32'(Overrun), 32'(m_ovr));
    chk("frame_err", 32'(Frame_Err), 32'(m_fe));
  endtask

  // One full word, Start on the MSB cycle; optional Ack on the bit-0 cycle.
  task automatic word(input logic [W-1:0] wa, wb, input bit ack_last);
    for (int i = W - 1; i >= 0; i--)
      cyc(0, i == W - 1, wa[i], wb[i], ack_last && i == 0);
  endtask

  initial begin
    logic [W-1:0] w1a, w1b, w2a, w2b;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 1);
    chk("reset_valid", 32'(Valid), 0);
    chk("reset_busy", 32'(Busy), 0);
    chk("reset_data", 32'({Data_A, Data_B}), 0);

    // single word: Valid visible W cycles after the Start cycle
    cyc(0, 0, 1, 1, 1);
    word(8'h05, 8'h0F, 0);
    chk("w1_valid", 32'(Valid), 1);
    chk("w1_da", 32'(Data_A), 32'h05);
    chk("w1_db", 32'(Data_B), 32'h0F);
    chk("w1_flags", 32'({Overrun, Frame_Err}), 0);
    cyc(0, 0, 0, 0, 1);
    chk("w1_acked", 32'(Valid), 0);

    // back-to-back: second Start shares the first word's bit-0 cycle
    w1a = 8'h81; w1b = 8'h40; w2a = 8'hC3; w2b = 8'h1E;
    for (int i = W - 1; i >= 1; i--) cyc(0, i == W - 1, w1a[i], w1b[i], 0);
    cyc(0, 1, w1a[0], w1b[0], 0);
    chk("b2b_first", 32'({Valid, Data_A, Data_B}), 32'({1'b1, w1a, w1b}));
    for (int i = W - 2; i >= 0; i--) cyc(0, 0, w2a[i], w2b[i], m_valid);
    cyc(0, 0, 0, 0, 0);
    chk("b2b_second", 32'({Valid, Data_A, Data_B}), 32'({1'b1, w2a, w2b}));
    chk("b2b_flags", 32'({Overrun, Frame_Err}), 0);

    // two words, no Ack: overrun, first word kept
    cyc(1, 0, 0, 0, 0);
    word(8'h12, 8'h34, 0);
    word(8'hAB, 8'hCD, 0);
    chk("ovr_keep", 32'({Data_A, Data_B}), 32'h1234);
    chk("ovr_flag", 32'({Valid, Overrun}), 32'b11);

    // Start after 3 bits aborts and restarts
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0); cyc(0, 0, 0, 1, 0); cyc(0, 0, 1, 1, 0);
    word(8'hA5, 8'h3C, 0);
    chk("fe_flag", 32'(Frame_Err), 1);
    chk("fe_data", 32'({Data_A, Data_B}), 32'hA53C);

    // reset mid-word, then a clean word
    cyc(0, 1, 0, 1, 0); cyc(0, 0, 1, 0, 0); cyc(0, 0, 0, 1, 0); cyc(0, 0, 1, 1, 0);
    cyc(1, 0, 1, 1, 1);
    chk("rst_mid", 32'({Data_A, Data_B, Valid, Busy, Overrun, Frame_Err}), 0);
    word(8'hFF, 8'h00, 0);
    chk("post_rst", 32'({Valid, Data_A, Data_B}), 32'({1'b1, 8'hFF, 8'h00}));

    // Ack coincides with second completion
    cyc(1, 0, 0, 0, 0);
    word(8'h11, 8'h22, 0);
    word(8'h66, 8'h99, 1);
    chk("ack_same", 32'({Valid, Overrun, Data_A, Data_B}), 32'({2'b10, 8'h66, 8'h99}));

    // random: free-running starts
    cyc(1, 0, 0, 0, 0);
    for (int n = 0; n < 300; n++)
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 9) == 0,
          1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
    // random: mostly well-framed words
    cyc(1, 0, 0, 0, 0);
    for (int n = 0; n < 400; n++)
      cyc($urandom_range(0, 199) == 0,
          (!m_busy || m_cnt == W - 1) && $urandom_range(0, 2) == 0,
          1'($urandom), 1'($urandom), $urandom_range(0, 4) == 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
